// File: rtl/b_resp_gen_if.sv
// Write-event inputs, status flags and the B response channel of one slave's B generator.
// The master modport is the B generator; the slave modport is the slave wrapper / crossbar side.
interface b_resp_gen_if #(
  parameter int ID_width   = 6,
  parameter int user_width = 6
);
  logic                  aw_fire;
  logic [ID_width-1:0]   aw_id;
  logic [user_width-1:0] aw_user;
  logic                  w_last_fire;
  logic                  w_err;
  logic                  aw_full;
  logic                  w_full;
  logic                  ovf_err;
  logic [ID_width-1:0]   s_BID;
  logic [1:0]            s_BRESP;
  logic                  s_BVALID;
  logic [user_width-1:0] s_BUSER;
  logic                  s_BREADY;

  modport master (
    input  aw_fire, aw_id, aw_user, w_last_fire, w_err, s_BREADY,
    output aw_full, w_full, ovf_err, s_BID, s_BRESP, s_BVALID, s_BUSER
  );

  modport slave (
    output aw_fire, aw_id, aw_user, w_last_fire, w_err, s_BREADY,
    input  aw_full, w_full, ovf_err, s_BID, s_BRESP, s_BVALID, s_BUSER
  );
endinterface

// File: rtl/b_resp_gen.sv
// Slave-side AXI write-response generator: queues accepted AW (id, user) and completed
// W bursts (error flag) in two independent FIFOs, pairs them in order and drives one
// registered B response per write, held stable until the crossbar accepts it.
module b_resp_gen #(
  parameter int ID_width   = 6,
  parameter int user_width = 6,
  parameter int DEPTH      = 4
) (
  input  logic clk,
  input  logic reset,
  b_resp_gen_if.master bus
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ID_width + user_width;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // FIFO storage (data only, never reset; validity comes from the counts)
  logic [ENTRY_W-1:0]    aw_mem_q [DEPTH];
  logic [1:0]            w_mem_q  [DEPTH];

  // FIFO bookkeeping
  logic [PTR_W-1:0]      aw_wptr_q, aw_wptr_d, aw_rptr_q, aw_rptr_d;
  logic [PTR_W-1:0]      w_wptr_q,  w_wptr_d,  w_rptr_q,  w_rptr_d;
  logic [CNT_W-1:0]      aw_cnt_q,  aw_cnt_d,  w_cnt_q,   w_cnt_d;
  logic                  ovf_q,     ovf_d;

  // B output register
  logic                  b_valid_q, b_valid_d;
  logic [ID_width-1:0]   b_id_q,    b_id_d;
  logic [user_width-1:0] b_user_q,  b_user_d;
  logic [1:0]            b_resp_q,  b_resp_d;

  logic aw_full_int, w_full_int;
  logic issue;
  logic aw_push, w_push;
  logic [1:0] w_push_resp;
  logic [ENTRY_W-1:0] aw_head;

  assign aw_full_int = (aw_cnt_q == CNT_W'(DEPTH));
  assign w_full_int  = (w_cnt_q  == CNT_W'(DEPTH));

  assign bus.aw_full  = aw_full_int;
  assign bus.w_full   = w_full_int;
  assign bus.ovf_err  = ovf_q;
  assign bus.s_BVALID = b_valid_q;
  assign bus.s_BID    = b_id_q;
  assign bus.s_BUSER  = b_user_q;
  assign bus.s_BRESP  = b_resp_q;

  // Decide issue/push/drop for this cycle and compute next FIFO and B-register state
  always_comb begin
    issue       = (aw_cnt_q != '0) && (w_cnt_q != '0) && (!b_valid_q || bus.s_BREADY);
    aw_push     = bus.aw_fire     && (!aw_full_int || issue);
    w_push      = bus.w_last_fire && (!w_full_int  || issue);
    w_push_resp = bus.w_err ? RESP_SLVERR : RESP_OKAY;
    aw_head     = aw_mem_q[aw_rptr_q];

    aw_wptr_d = aw_push ? aw_wptr_q + PTR_W'(1) : aw_wptr_q;
    aw_rptr_d = issue   ? aw_rptr_q + PTR_W'(1) : aw_rptr_q;
    w_wptr_d  = w_push  ? w_wptr_q  + PTR_W'(1) : w_wptr_q;
    w_rptr_d  = issue   ? w_rptr_q  + PTR_W'(1) : w_rptr_q;

    aw_cnt_d = aw_cnt_q;
    if (aw_push && !issue) aw_cnt_d = aw_cnt_q + CNT_W'(1);
    else if (!aw_push && issue) aw_cnt_d = aw_cnt_q - CNT_W'(1);

    w_cnt_d = w_cnt_q;
    if (w_push && !issue) w_cnt_d = w_cnt_q + CNT_W'(1);
    else if (!w_push && issue) w_cnt_d = w_cnt_q - CNT_W'(1);

    ovf_d = ovf_q || (bus.aw_fire && !aw_push) || (bus.w_last_fire && !w_push);

    b_valid_d = b_valid_q;
    b_id_d    = b_id_q;
    b_user_d  = b_user_q;
    b_resp_d  = b_resp_q;
    if (issue) begin
      b_valid_d = 1'b1;
      b_id_d    = aw_head[ENTRY_W-1:user_width];
      b_user_d  = aw_head[user_width-1:0];
      b_resp_d  = w_mem_q[w_rptr_q];
    end else if (b_valid_q && bus.s_BREADY) begin
      b_valid_d = 1'b0;
    end
  end

  // Control state: pointers, counts, sticky overflow and the B register, synchronously reset
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_wptr_q <= '0;
      aw_rptr_q <= '0;
      w_wptr_q  <= '0;
      w_rptr_q  <= '0;
      aw_cnt_q  <= '0;
      w_cnt_q   <= '0;
      ovf_q     <= 1'b0;
      b_valid_q <= 1'b0;
      b_id_q    <= '0;
      b_user_q  <= '0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      aw_wptr_q <= aw_wptr_d;
      aw_rptr_q <= aw_rptr_d;
      w_wptr_q  <= w_wptr_d;
      w_rptr_q  <= w_rptr_d;
      aw_cnt_q  <= aw_cnt_d;
      w_cnt_q   <= w_cnt_d;
      ovf_q     <= ovf_d;
      b_valid_q <= b_valid_d;
      b_id_q    <= b_id_d;
      b_user_q  <= b_user_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // FIFO data writes; a full FIFO is written only when the same cycle pops its head slot
  always_ff @(posedge clk) begin
    if (!reset && aw_push) aw_mem_q[aw_wptr_q] <= {bus.aw_id, bus.aw_user};
    if (!reset && w_push)  w_mem_q[w_wptr_q]   <= w_push_resp;
  end

endmodule

// File: tb/tb_b_resp_gen.sv
// Directed self-checking bench for b_resp_gen. Cycle c of each scenario starts at the
// clock edge following the scenario's reset; inputs are driven and registered outputs
// are checked 1ns after that edge.
module tb_b_resp_gen;
  localparam int IDW   = 6;
  localparam int UW    = 6;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  b_resp_gen_if #(.ID_width(IDW), .user_width(UW)) bus ();

  b_resp_gen #(.ID_width(IDW), .user_width(UW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.aw_fire     = 1'b0;
    bus.aw_id       = '0;
    bus.aw_user     = '0;
    bus.w_last_fire = 1'b0;
    bus.w_err       = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    bus.s_BREADY = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.s_BVALID !== 1'b0) begin failures++; $display("FAIL reset_bvalid got=%b exp=0", bus.s_BVALID); end
    checks++; if (bus.s_BID !== 6'h00) begin failures++; $display("FAIL reset_bid got=%h exp=00", bus.s_BID); end
    checks++; if (bus.s_BRESP !== 2'b00) begin failures++; $display("FAIL reset_bresp got=%b exp=00", bus.s_BRESP); end
    checks++; if (bus.s_BUSER !== 6'h00) begin failures++; $display("FAIL reset_buser got=%h exp=00", bus.s_BUSER); end
    checks++; if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf_err); end
    checks++; if (bus.aw_full !== 1'b0) begin failures++; $display("FAIL reset_aw_full got=%b exp=0", bus.aw_full); end
    checks++; if (bus.w_full !== 1'b0) begin failures++; $display("FAIL reset_w_full got=%b exp=0", bus.w_full); end
  endtask

  task automatic test_single_write();
    logic exp_v;
    do_reset();
    bus.s_BREADY = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      idle();
      if (c == 3) begin bus.aw_fire = 1'b1; bus.aw_id = 6'h15; bus.aw_user = 6'h2A; end
      if (c == 5) begin bus.w_last_fire = 1'b1; bus.w_err = 1'b0; end
      exp_v = (c == 7);
      checks++; if (bus.s_BVALID !== exp_v) begin failures++; $display("FAIL single_bvalid cyc=%0d got=%b exp=%b", c, bus.s_BVALID, exp_v); end
      if (c == 7) begin
        checks++; if (bus.s_BID !== 6'h15) begin failures++; $display("FAIL single_bid got=%h exp=15", bus.s_BID); end
        checks++; if (bus.s_BUSER !== 6'h2A) begin failures++; $display("FAIL single_buser got=%h exp=2a", bus.s_BUSER); end
        checks++; if (bus.s_BRESP !== 2'b00) begin failures++; $display("FAIL single_bresp got=%b exp=00", bus.s_BRESP); end
      end
      tick();
    end
  endtask

  task automatic test_w_before_aw();
    logic exp_v;
    do_reset();
    bus.s_BREADY = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      idle();
      if (c == 2) begin bus.w_last_fire = 1'b1; bus.w_err = 1'b1; end
      if (c == 6) begin bus.aw_fire = 1'b1; bus.aw_id = 6'h03; bus.aw_user = 6'h11; end
      exp_v = (c == 8);
      checks++; if (bus.s_BVALID !== exp_v) begin failures++; $display("FAIL wfirst_bvalid cyc=%0d got=%b exp=%b", c, bus.s_BVALID, exp_v); end
      if (c == 8) begin
        checks++; if (bus.s_BID !== 6'h03) begin failures++; $display("FAIL wfirst_bid got=%h exp=03", bus.s_BID); end
        checks++; if (bus.s_BRESP !== 2'b10) begin failures++; $display("FAIL wfirst_bresp got=%b exp=10", bus.s_BRESP); end
        checks++; if (bus.s_BUSER !== 6'h11) begin failures++; $display("FAIL wfirst_buser got=%h exp=11", bus.s_BUSER); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic       exp_v;
    logic [5:0] exp_id;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      idle();
      bus.s_BREADY = (c >= 10);
      if (c <= 2) begin
        bus.aw_fire = 1'b1; bus.aw_id = 6'(c + 1); bus.aw_user = 6'(c + 1);
        bus.w_last_fire = 1'b1;
      end
      exp_v  = (c >= 2 && c <= 12);
      exp_id = (c <= 10) ? 6'h01 : 6'(c - 9);
      checks++; if (bus.s_BVALID !== exp_v) begin failures++; $display("FAIL bp_bvalid cyc=%0d got=%b exp=%b", c, bus.s_BVALID, exp_v); end
      if (exp_v) begin
        checks++; if (bus.s_BID !== exp_id) begin failures++; $display("FAIL bp_bid cyc=%0d got=%h exp=%h", c, bus.s_BID, exp_id); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_v;
    logic [5:0] exp_id;
    logic [1:0] exp_resp;
    do_reset();
    bus.s_BREADY = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      idle();
      if (c <= 3) begin
        bus.aw_fire = 1'b1; bus.aw_id = 6'(8 + c); bus.aw_user = 6'(8 + c) ^ 6'h3F;
        bus.w_last_fire = 1'b1; bus.w_err = (c % 2 == 1);
      end
      exp_v    = (c >= 2 && c <= 5);
      exp_id   = 6'(8 + c - 2);
      exp_resp = ((c - 2) % 2 == 1) ? 2'b10 : 2'b00;
      checks++; if (bus.s_BVALID !== exp_v) begin failures++; $display("FAIL b2b_bvalid cyc=%0d got=%b exp=%b", c, bus.s_BVALID, exp_v); end
      if (exp_v) begin
        checks++; if (bus.s_BID !== exp_id) begin failures++; $display("FAIL b2b_bid cyc=%0d got=%h exp=%h", c, bus.s_BID, exp_id); end
        checks++; if (bus.s_BUSER !== (exp_id ^ 6'h3F)) begin failures++; $display("FAIL b2b_buser cyc=%0d got=%h exp=%h", c, bus.s_BUSER, exp_id ^ 6'h3F); end
        checks++; if (bus.s_BRESP !== exp_resp) begin failures++; $display("FAIL b2b_bresp cyc=%0d got=%b exp=%b", c, bus.s_BRESP, exp_resp); end
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    logic       exp_v, exp_full, exp_ovf;
    logic [5:0] exp_id;
    int         resp_count;
    resp_count = 0;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      idle();
      bus.s_BREADY = (c >= 6);
      if (c <= 5) begin bus.aw_fire = 1'b1; bus.aw_id = 6'(16 + c); bus.aw_user = 6'(c); end
      if (c >= 6 && c <= 9) bus.w_last_fire = 1'b1;
      exp_full = (c >= 4 && c <= 7);
      exp_ovf  = (c >= 5);
      exp_v    = (c >= 8 && c <= 11);
      exp_id   = 6'(16 + c - 8);
      checks++; if (bus.aw_full !== exp_full) begin failures++; $display("FAIL ovf_aw_full cyc=%0d got=%b exp=%b", c, bus.aw_full, exp_full); end
      checks++; if (bus.ovf_err !== exp_ovf) begin failures++; $display("FAIL ovf_err cyc=%0d got=%b exp=%b", c, bus.ovf_err, exp_ovf); end
      checks++; if (bus.s_BVALID !== exp_v) begin failures++; $display("FAIL ovf_bvalid cyc=%0d got=%b exp=%b", c, bus.s_BVALID, exp_v); end
      if (bus.s_BVALID === 1'b1) resp_count++;
      if (exp_v) begin
        checks++; if (bus.s_BID !== exp_id) begin failures++; $display("FAIL ovf_bid cyc=%0d got=%h exp=%h", c, bus.s_BID, exp_id); end
      end
      tick();
    end
    checks++; if (resp_count != 4) begin failures++; $display("FAIL ovf_resp_count got=%0d exp=4", resp_count); end
  endtask

  task automatic test_w_full();
    logic exp_full, exp_ovf;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      idle();
      if (c <= 4) bus.w_last_fire = 1'b1;
      exp_full = (c >= 4);
      exp_ovf  = (c >= 5);
      checks++; if (bus.w_full !== exp_full) begin failures++; $display("FAIL wfull_flag cyc=%0d got=%b exp=%b", c, bus.w_full, exp_full); end
      checks++; if (bus.ovf_err !== exp_ovf) begin failures++; $display("FAIL wfull_ovf cyc=%0d got=%b exp=%b", c, bus.ovf_err, exp_ovf); end
      checks++; if (bus.s_BVALID !== 1'b0) begin failures++; $display("FAIL wfull_bvalid cyc=%0d got=%b exp=0", c, bus.s_BVALID); end
      tick();
    end
  endtask

  task automatic test_full_simul_pop();
    logic       exp_v, exp_full;
    logic [5:0] exp_id;
    do_reset();
    bus.s_BREADY = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      idle();
      if (c <= 3 || c == 5) begin bus.aw_fire = 1'b1; bus.aw_id = 6'(32 + ((c == 5) ? 4 : c)); end
      if (c == 4 || (c >= 6 && c <= 9)) bus.w_last_fire = 1'b1;
      exp_full = (c >= 4 && c <= 7);
      exp_v    = (c == 6) || (c >= 8 && c <= 11);
      exp_id   = (c == 6) ? 6'h20 : 6'(33 + c - 8);
      checks++; if (bus.aw_full !== exp_full) begin failures++; $display("FAIL simul_aw_full cyc=%0d got=%b exp=%b", c, bus.aw_full, exp_full); end
      checks++; if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL simul_ovf cyc=%0d got=%b exp=0", c, bus.ovf_err); end
      checks++; if (bus.s_BVALID !== exp_v) begin failures++; $display("FAIL simul_bvalid cyc=%0d got=%b exp=%b", c, bus.s_BVALID, exp_v); end
      if (exp_v) begin
        checks++; if (bus.s_BID !== exp_id) begin failures++; $display("FAIL simul_bid cyc=%0d got=%h exp=%h", c, bus.s_BID, exp_id); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic exp_v;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      idle();
      bus.s_BREADY = (c >= 7);
      reset = (c == 6);
      if (c <= 2) begin
        bus.aw_fire = 1'b1; bus.aw_id = 6'(49 + c); bus.aw_user = 6'h05;
        bus.w_last_fire = 1'b1; bus.w_err = 1'b1;
      end
      if (c == 3 || c == 4) begin bus.aw_fire = 1'b1; bus.aw_id = 6'(c); end
      if (c == 8) begin
        bus.aw_fire = 1'b1; bus.aw_id = 6'h3A; bus.aw_user = 6'h01;
        bus.w_last_fire = 1'b1; bus.w_err = 1'b0;
      end
      if (c == 5) begin
        checks++; if (bus.aw_full !== 1'b1) begin failures++; $display("FAIL rmid_pre_full got=%b exp=1", bus.aw_full); end
        checks++; if (bus.s_BVALID !== 1'b1) begin failures++; $display("FAIL rmid_pre_bvalid got=%b exp=1", bus.s_BVALID); end
      end
      if (c == 7) begin
        checks++; if (bus.s_BID !== 6'h00) begin failures++; $display("FAIL rmid_bid got=%h exp=00", bus.s_BID); end
        checks++; if (bus.s_BRESP !== 2'b00) begin failures++; $display("FAIL rmid_bresp got=%b exp=00", bus.s_BRESP); end
        checks++; if (bus.s_BUSER !== 6'h00) begin failures++; $display("FAIL rmid_buser got=%h exp=00", bus.s_BUSER); end
        checks++; if (bus.aw_full !== 1'b0) begin failures++; $display("FAIL rmid_aw_full got=%b exp=0", bus.aw_full); end
      end
      if (c >= 7) begin
        exp_v = (c == 10);
        checks++; if (bus.s_BVALID !== exp_v) begin failures++; $display("FAIL rmid_bvalid cyc=%0d got=%b exp=%b", c, bus.s_BVALID, exp_v); end
        if (c == 10) begin
          checks++; if (bus.s_BID !== 6'h3A) begin failures++; $display("FAIL rmid_post_bid got=%h exp=3a", bus.s_BID); end
          checks++; if (bus.s_BRESP !== 2'b00) begin failures++; $display("FAIL rmid_post_bresp got=%b exp=00", bus.s_BRESP); end
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.s_BREADY = 1'b0;
    idle();
    test_reset();
    test_single_write();
    test_w_before_aw();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_w_full();
    test_full_simul_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
